// File: rtl/axi_fifo_port.sv
// axi_fifo_port: CPU-facing byte FIFO peripheral.
// A TX FIFO is filled by CPU writes to DATA and drains onto a valid/ready stream.
// An RX FIFO is filled from an always-accepted input stream and popped by CPU reads of DATA.
// STATUS exposes full/empty flags, occupancy counts and sticky error flags.
// CTRL clears the sticky flags and flushes either FIFO.
module axi_fifo_port #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        avalid,
  output logic        aready,
  input  logic        awe,
  input  logic [31:2] aaddr,
  input  logic [31:0] adata,
  input  logic [3:0]  astrb,
  output logic        bvalid,
  output logic [31:0] bdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data
);

  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // Storage and state
  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    rx_mem_q [DEPTH];
  logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          bvalid_q;
  logic [31:0]   bdata_q, rdata_d;

  // Decoded events
  logic [1:0]  sel_s;
  logic        acc_s;
  logic        tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic        tx_push_s, tx_pop_s, tx_flush_s;
  logic        rx_push_s, rx_pop_s, rx_rd_req_s, rx_flush_s;
  logic        clr_s, ovf_evt_s, unf_evt_s;
  logic [7:0]  rx_head_s, tx_cnt8_s, rx_cnt8_s;
  logic [31:0] status_s;
  logic        unused_s;

  assign unused_s = ^{aaddr[31:4], adata[31:8], astrb[3:1]};

  assign sel_s      = aaddr[3:2];
  assign tx_full_s  = (tx_cnt_q == CNT_FULL);
  assign tx_empty_s = (tx_cnt_q == {CW{1'b0}});
  assign rx_full_s  = (rx_cnt_q == CNT_FULL);
  assign rx_empty_s = (rx_cnt_q == {CW{1'b0}});

  assign tx_valid = !tx_empty_s;
  assign tx_data  = tx_empty_s ? 8'h00 : tx_mem_q[tx_rp_q];
  assign tx_pop_s = tx_valid && tx_ready;

  // A TX push stalls only while TX is full and the stream is not freeing a slot this cycle.
  assign aready = !(avalid && awe && (sel_s == 2'd0) && astrb[0] && tx_full_s && !tx_pop_s);
  assign acc_s  = avalid && aready;

  assign rx_head_s = rx_empty_s ? 8'h00 : rx_mem_q[rx_rp_q];
  assign tx_cnt8_s = 8'(tx_cnt_q);
  assign rx_cnt8_s = 8'(rx_cnt_q);
  assign status_s  = {8'h00, rx_cnt8_s, tx_cnt8_s, 2'b00, unf_q, ovf_q,
                      rx_full_s, rx_empty_s, tx_empty_s, tx_full_s};

  assign bvalid = bvalid_q;
  assign bdata  = bdata_q;

  // Request decode: pushes, pops, flushes, flag clears and error events for this cycle.
  always_comb begin
    tx_push_s   = 1'b0;
    tx_flush_s  = 1'b0;
    rx_flush_s  = 1'b0;
    clr_s       = 1'b0;
    rx_rd_req_s = 1'b0;
    if (acc_s && awe) begin
      tx_push_s  = (sel_s == 2'd0) && astrb[0];
      clr_s      = (sel_s == 2'd2) && astrb[0] && adata[0];
      tx_flush_s = (sel_s == 2'd2) && astrb[0] && adata[1];
      rx_flush_s = (sel_s == 2'd2) && astrb[0] && adata[2];
    end else begin
      rx_rd_req_s = acc_s && (sel_s == 2'd0);
    end
    rx_pop_s  = rx_rd_req_s && !rx_empty_s;
    unf_evt_s = rx_rd_req_s && rx_empty_s;
    // A byte arriving at a full RX is kept only if the CPU frees a slot in the same cycle.
    rx_push_s = rx_valid && !rx_flush_s && (!rx_full_s || rx_pop_s);
    ovf_evt_s = rx_valid && !rx_flush_s && rx_full_s && !rx_pop_s;
  end

  // TX pointer/count next state; flush overrides any push or pop.
  always_comb begin
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_flush_s) begin
      tx_wp_d  = {PW{1'b0}};
      tx_rp_d  = {PW{1'b0}};
      tx_cnt_d = {CW{1'b0}};
    end else begin
      if (tx_push_s) tx_wp_d = tx_wp_q + PTR_ONE;
      else           tx_wp_d = tx_wp_q;
      if (tx_pop_s)  tx_rp_d = tx_rp_q + PTR_ONE;
      else           tx_rp_d = tx_rp_q;
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
        2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
        default: tx_cnt_d = tx_cnt_q;
      endcase
    end
  end

  // RX pointer/count next state; flush overrides any push or pop.
  always_comb begin
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_flush_s) begin
      rx_wp_d  = {PW{1'b0}};
      rx_rp_d  = {PW{1'b0}};
      rx_cnt_d = {CW{1'b0}};
    end else begin
      if (rx_push_s) rx_wp_d = rx_wp_q + PTR_ONE;
      else           rx_wp_d = rx_wp_q;
      if (rx_pop_s)  rx_rp_d = rx_rp_q + PTR_ONE;
      else           rx_rp_d = rx_rp_q;
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
        2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
        default: rx_cnt_d = rx_cnt_q;
      endcase
    end
  end

  // Sticky flags: a new event in the same cycle as a clear leaves the flag set.
  always_comb begin
    ovf_d = (ovf_q && !clr_s) || ovf_evt_s;
    unf_d = (unf_q && !clr_s) || unf_evt_s;
  end

  // Read data mux; writes always respond with zero.
  always_comb begin
    rdata_d = 32'h0000_0000;
    if (!awe) begin
      case (sel_s)
        2'd0:    rdata_d = {24'h00_0000, rx_head_s};
        2'd1:    rdata_d = status_s;
        default: rdata_d = 32'h0000_0000;
      endcase
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q  <= {PW{1'b0}};
      tx_rp_q  <= {PW{1'b0}};
      tx_cnt_q <= {CW{1'b0}};
      rx_wp_q  <= {PW{1'b0}};
      rx_rp_q  <= {PW{1'b0}};
      rx_cnt_q <= {CW{1'b0}};
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // FIFO storage writes at the current write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem_q[i] <= 8'h00;
        rx_mem_q[i] <= 8'h00;
      end
    end else begin
      if (tx_push_s) tx_mem_q[tx_wp_q] <= adata[7:0];
      if (rx_push_s) rx_mem_q[rx_wp_q] <= rx_data;
    end
  end

  // Registered single-cycle response for every accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_q <= 1'b0;
      bdata_q  <= 32'h0000_0000;
    end else begin
      bvalid_q <= acc_s;
      bdata_q  <= acc_s ? rdata_d : 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_axi_fifo_port.sv
// Directed bench for axi_fifo_port with hand-computed expected values.
module tb_axi_fifo_port;

  logic        clk;
  logic        rst_n;
  logic        avalid;
  logic        aready;
  logic        awe;
  logic [31:2] aaddr;
  logic [31:0] adata;
  logic [3:0]  astrb;
  logic        bvalid;
  logic [31:0] bdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;

  axi_fifo_port #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .avalid(avalid), .aready(aready), .awe(awe), .aaddr(aaddr),
    .adata(adata), .astrb(astrb), .bvalid(bvalid), .bdata(bdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: drive at negedge, wait (bounded) for aready, accepted at posedge.
  task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r);
    int n;
    @(negedge clk);
    avalid = 1'b1; awe = we; aaddr = {28'h000_0000, a}; adata = d; astrb = s;
    #1;
    n = 0;
    while (!aready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) check("aready_timeout", {31'b0, aready}, 32'd1);
    @(posedge clk); #1;
    avalid = 1'b0; awe = 1'b0;
    check("bvalid", {31'b0, bvalid}, 32'd1);
    if (we) check("bdata_wr", bdata, 32'h0);
    r = bdata;
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; avalid = 1'b0; awe = 1'b0; aaddr = '0; adata = 32'h0;
    astrb = 4'h0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_aready", {31'b0, aready}, 32'd1);
    check("rst_bvalid", {31'b0, bvalid}, 32'd0);
    check("rst_txvalid", {31'b0, tx_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Mid-stream reset discards the pending response and TX contents
    bus(1'b1, 2'd0, 32'h0000_00AB, 4'h1, rd);
    check("tx_valid_after_wr", {31'b0, tx_valid}, 32'd1);
    check("tx_data_after_wr", {24'b0, tx_data}, 32'h0000_00AB);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", {31'b0, bvalid}, 32'd0);
    check("mid_rst_bdata", bdata, 32'h0);
    check("mid_rst_txvalid", {31'b0, tx_valid}, 32'd0);
    check("mid_rst_txdata", {24'b0, tx_data}, 32'h0);
    check("mid_rst_aready", {31'b0, aready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    bus(1'b0, 2'd1, 32'h0, 4'h0, rd);
    check("status_after_rst", rd, 32'h0000_0006);

    // TX drain ordering
    bus(1'b1, 2'd0, 32'h0000_0011, 4'h1, rd);
    bus(1'b1, 2'd0, 32'h0000_0022, 4'h1, rd);
    bus(1'b1, 2'd0, 32'h0000_0033, 4'h1, rd);
    bus(1'b0, 2'd1, 32'h0, 4'h0, rd);
    check("status_tx3", rd, 32'h0000_0304);
    @(negedge clk); tx_ready = 1'b1; #1;
    check("drain0", {24'b0, tx_data}, 32'h11);
    @(negedge clk); #1;
    check("drain1", {24'b0, tx_data}, 32'h22);
    @(negedge clk); #1;
    check("drain2", {24'b0, tx_data}, 32'h33);
    @(negedge clk); #1;
    check("drain_empty", {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // TX full stall: 16 writes, then a 17th held until a pop frees a slot
    for (int i = 0; i < 16; i++) bus(1'b1, 2'd0, 32'h40 + i, 4'h1, rd);
    bus(1'b0, 2'd1, 32'h0, 4'h0, rd);
    check("status_tx_full", rd, 32'h0000_1005);
    @(negedge clk);
    avalid = 1'b1; awe = 1'b1; aaddr = '0; adata = 32'h99; astrb = 4'h1;
    #1 check("stall_aready0", {31'b0, aready}, 32'd0);
    @(negedge clk); #1;
    check("stall_aready1", {31'b0, aready}, 32'd0);
    tx_ready = 1'b1; #1;
    check("stall_release", {31'b0, aready}, 32'd1);
    @(posedge clk); #1;
    avalid = 1'b0; awe = 1'b0; tx_ready = 1'b0;
    check("stall_bvalid", {31'b0, bvalid}, 32'd1);
    check("stall_head", {24'b0, tx_data}, 32'h41);
    bus(1'b0, 2'd1, 32'h0, 4'h0, rd);
    check("status_still_full", rd, 32'h0000_1005);
    @(negedge clk); tx_ready = 1'b1; #1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      check("full_drain", {24'b0, tx_data}, (i < 15) ? (32'h41 + i) : 32'h99);
    end
    @(negedge clk); #1;
    check("full_drain_empty", {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // Strobe-gated write, CTRL and reserved reads
    bus(1'b1, 2'd0, 32'h12, 4'hE, rd);
    check("strb0_ignored", {31'b0, tx_valid}, 32'd0);
    bus(1'b0, 2'd2, 32'h0, 4'h0, rd);
    check("ctrl_read0", rd, 32'h0);
    bus(1'b0, 2'd3, 32'h0, 4'h0, rd);
    check("rsvd_read0", rd, 32'h0);

    // RX overflow and underflow
    for (int i = 0; i < 17; i++) rx_push(8'(i));
    bus(1'b0, 2'd1, 32'h0, 4'h0, rd);
    check("status_rx_ovf", rd, 32'h0010_001A);
    for (int i = 0; i < 16; i++) begin
      bus(1'b0, 2'd0, 32'h0, 4'h0, rd);
      check("rx_read", rd, i);
    end
    bus(1'b0, 2'd0, 32'h0, 4'h0, rd);
    check("rx_underflow_read", rd, 32'h0);
    bus(1'b0, 2'd1, 32'h0, 4'h0, rd);
    check("status_flags", rd, 32'h0000_0036);
    bus(1'b1, 2'd2, 32'h1, 4'h1, rd);
    bus(1'b0, 2'd1, 32'h0, 4'h0, rd);
    check("status_cleared", rd, 32'h0000_0006);

    // Underflow read concurrent with a push into empty RX
    @(negedge clk);
    avalid = 1'b1; awe = 1'b0; aaddr = '0; astrb = 4'h0;
    rx_valid = 1'b1; rx_data = 8'h5A;
    @(posedge clk); #1;
    avalid = 1'b0; rx_valid = 1'b0;
    check("unf_push_bdata", bdata, 32'h0);
    bus(1'b0, 2'd1, 32'h0, 4'h0, rd);
    check("unf_push_status", rd, 32'h0001_0022);
    bus(1'b0, 2'd0, 32'h0, 4'h0, rd);
    check("unf_push_kept", rd, 32'h5A);
    bus(1'b1, 2'd2, 32'h1, 4'h1, rd);

    // Simultaneous push/pop at full across pointer wrap
    for (int i = 0; i < 5; i++) rx_push(8'hA0 + 8'(i));
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, 2'd0, 32'h0, 4'h0, rd);
      check("wrap_pre_read", rd, 32'hA0 + i);
    end
    for (int i = 0; i < 16; i++) rx_push(8'hB0 + 8'(i));
    @(negedge clk);
    avalid = 1'b1; awe = 1'b0; aaddr = '0; astrb = 4'h0;
    rx_valid = 1'b1; rx_data = 8'hC0;
    @(posedge clk); #1;
    avalid = 1'b0; rx_valid = 1'b0;
    check("full_pp_bdata", bdata, 32'hB0);
    bus(1'b0, 2'd1, 32'h0, 4'h0, rd);
    check("full_pp_status", rd, 32'h0010_000A);
    for (int i = 1; i < 17; i++) begin
      bus(1'b0, 2'd0, 32'h0, 4'h0, rd);
      check("wrap_order", rd, (i < 16) ? (32'hB0 + i) : 32'hC0);
    end
    bus(1'b0, 2'd1, 32'h0, 4'h0, rd);
    check("wrap_status_empty", rd, 32'h0000_0006);

    // Flush both FIFOs in the same cycle as an RX push
    bus(1'b1, 2'd0, 32'h55, 4'h1, rd);
    bus(1'b1, 2'd0, 32'h66, 4'h1, rd);
    rx_push(8'h77);
    @(negedge clk);
    avalid = 1'b1; awe = 1'b1; aaddr = {28'h0, 2'd2}; adata = 32'h6; astrb = 4'h1;
    rx_valid = 1'b1; rx_data = 8'h88;
    @(posedge clk); #1;
    avalid = 1'b0; awe = 1'b0; rx_valid = 1'b0;
    check("flush_bvalid", {31'b0, bvalid}, 32'd1);
    check("flush_txvalid", {31'b0, tx_valid}, 32'd0);
    bus(1'b0, 2'd1, 32'h0, 4'h0, rd);
    check("flush_status", rd, 32'h0000_0006);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_fifo_port.md
# axi_fifo_port

Byte-stream FIFO peripheral that sits directly downstream of the CPU bridge as a slave on the `avalid/aready/awe/aaddr/adata/astrb` → `bvalid/bdata` request bus. CPU writes to a DATA register push bytes into a TX FIFO, which drains onto a valid/ready output stream. Bytes arriving on an always-accepted RX input stream fill an RX FIFO, which the CPU pops by reading DATA. Status, occupancy counts and sticky error flags are readable; flushes and flag clears are done through a control register.

## Interface
- `DEPTH_LOG2`, default 4: each FIFO holds 2^DEPTH_LOG2 bytes. Legal range 1..7.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `avalid` in 1: request valid.
- `aready` out 1: request accepted when `avalid && aready`.
- `awe` in 1: 1 = write, 0 = read.
- `aaddr` in 30 [31:2]: word address. Only [3:2] is decoded; upstream decoding selects this block.
- `adata` in 32: write data.
- `astrb` in 4: byte strobes.
- `bvalid` out 1: single-cycle response pulse, issued for reads and writes.
- `bdata` out 32: read data, valid with `bvalid`. 0 for writes.
- `tx_valid` out 1: TX stream valid, equal to !tx_empty.
- `tx_data` out 8: TX head byte (first-word fall-through).
- `tx_ready` in 1: TX consumer ready. A pop occurs on `tx_valid && tx_ready`.
- `rx_valid` in 1: RX byte present. There is no ready signal.
- `rx_data` in 8: RX byte.

## Operation
- Register map by `aaddr[3:2]`:
  - **0 DATA**
    - Write with `astrb[0]`=1 pushes `adata[7:0]` to TX. A write with `astrb[0]`=0 is ignored but still responded to.
    - Read pops RX; `bdata={24'b0,head}`. Reading an empty RX returns 0, pops nothing and sets `rx_underflow`.
  - **1 STATUS** (read-only)
    - bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full.
    - bit4 rx_overflow (sticky), bit5 rx_underflow (sticky).
    - [15:8] tx_count, [23:16] rx_count, each zero-extended from DEPTH_LOG2+1 bits. Other bits 0.
  - **2 CTRL**
    - Write only, gated by `astrb[0]`. bit0=1 clears both sticky flags; bit1=1 flushes TX; bit2=1 flushes RX.
    - Reads return 0.
  - **3**: reserved. Reads 0, writes ignored.
- `aready` rule:
  - `aready` = !(avalid && awe && aaddr[3:2]==0 && astrb[0] && tx_full && !(tx_valid && tx_ready)).
  - This stalls a TX push while TX is full, and accepts it in the same cycle the stream frees a slot.
  - All other requests are accepted immediately.
- Response: `bvalid`=1 exactly one cycle after acceptance. It is registered, together with `bdata`. Every accepted request gets exactly one response.
- RX input:
  - Each cycle with `rx_valid`=1 pushes `rx_data`.
  - If RX is full and no CPU pop happens in the same cycle, the byte is dropped and `rx_overflow` is set.
- FIFO storage: circular buffers with DEPTH_LOG2-bit pointers that wrap modulo depth. Counts are DEPTH_LOG2+1 bits wide, range 0..2^DEPTH_LOG2.
- Simultaneous events within one cycle:
  - Push+pop on the same FIFO: both happen and the count is unchanged. This holds at full (RX: no overflow) and at empty+1.
  - Flush with push: flush wins and the push is dropped. For RX this does not set overflow.
  - Flag clear with a new overflow/underflow event: the flag ends set.
  - An RX-read underflow in the same cycle as an `rx_valid` push into an empty FIFO: the read returns 0 and flags underflow; the pushed byte stays.

## Timing
- Reset (asynchronous assert): FIFOs empty, pointers and counts 0, sticky flags 0.
- Output values during reset:
  - `bvalid`=0, `bdata`=0, `tx_valid`=0, `tx_data`=0.
  - `aready`=1 (combinational; FIFO not full).
- Reset mid-transaction: any pending response is discarded (`bvalid` goes to 0 immediately).
- Latencies:
  - Request to response: 1 cycle. Back-to-back requests are allowed: a new request may be accepted in the same cycle that `bvalid` is high.
  - CPU DATA write to `tx_valid`: `tx_valid` rises the cycle after acceptance.
  - `rx_valid` to rx_count/STATUS: visible in the cycle after the push edge.
- STATUS read value reflects the state at the acceptance edge, before that cycle's updates.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream → all outputs 0 except `aready`=1; then STATUS reads 0x00000006.
- **TX drain:** write 0x11, 0x22, 0x33 to DATA with `tx_ready`=0, then `tx_ready`=1 → `tx_data` sequence 11, 22, 33 on consecutive cycles; `tx_valid` then falls; each write gets `bvalid` one cycle after acceptance.
- **TX full stall:** DEPTH_LOG2=4, 16 writes → STATUS bit0=1, [15:8]=16. A 17th write holds `aready`=0 until `tx_ready` pulses; it is accepted in that cycle, and the count stays 16.
- **RX overflow:** push 17 bytes 0x00..0x10 → rx_overflow=1, and reads return 0x00..0x0F. An 18th read returns 0 and sets underflow. CTRL write 0x1 clears both flags (STATUS bits 4,5 = 0).
- **Simultaneous at full:** RX full, `rx_valid` in the same cycle as a DATA read → no overflow, count stays 16, FIFO order preserved across pointer wrap.
- **Flush vs push:** CTRL write 0x6 in the same cycle as `rx_valid` and `tx_ready`=0 → both FIFOs empty, overflow=0, `tx_valid`=0.
